fpadd_mant_pipe: RTL and testbench

Pipelined, parametrised mantissa datapath for the floating-point adder. It accepts two unpacked operands (sign, biased exponent, significand with explicit leading one) and a requested operation. It then performs magnitude compare/swap, alignment with guard/round/sticky collection, and effective add/subtract over three registered stages. Its output is an unnormalised sum with GRS bits, the result exponent and sign, and a zero flag, ready for the normalise/round block.

---
 rtl/fpadd_mant_pipe_pkg.sv | 10 +
 rtl/fpadd_align_shift.sv | 28 ++
 rtl/fpadd_mant_pipe.sv | 148 ++++++++++++++
 tb/tb_fpadd_mant_pipe.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpadd_mant_pipe_pkg.sv
// Shared constants for the floating-point adder datapath blocks
// (mantissa pipe and normalise/round).
package fpadd_mant_pipe_pkg;

    localparam int unsigned WEXP_DEF = 8;
    localparam int unsigned WSIG_DEF = 23;
    localparam int unsigned GRS_W    = 3;
    localparam int unsigned N_STAGES = 3;

endpackage

// File: rtl/fpadd_align_shift.sv
// Right barrel shifter with saturating shift amount; the LSB of the result
// is the sticky OR of every bit landing at or below the LSB position.
module fpadd_align_shift #(
    parameter int unsigned W    = 28,
    parameter int unsigned WAMT = 8
) (
    input  logic [W-1:0]    din,
    input  logic [WAMT-1:0] amt,
    output logic [W-1:0]    dout
);

    int unsigned sh;
    logic [W-1:0] ones;
    logic [W-1:0] shifted;
    logic [W-1:0] lost_mask;
    logic         sticky;

    always_comb begin
        ones      = '1;
        sh        = (32'(amt) >= W - 1) ? W - 1 : 32'(amt);
        shifted   = din >> sh;
        // bits din[sh:0] end up in the sticky position or fall off the end
        lost_mask = ~(ones << (sh + 1));
        sticky    = |(din & lost_mask);
        dout      = {shifted[W-1:1], sticky};
    end

endmodule

// File: rtl/fpadd_mant_pipe.sv
// Three-stage mantissa datapath of the FP adder: compare/swap, align with GRS,
// effective add/subtract. Single global enable stalls all stages together.
module fpadd_mant_pipe
    import fpadd_mant_pipe_pkg::*;
#(
    parameter int unsigned WEXP = WEXP_DEF,
    parameter int unsigned WSIG = WSIG_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            a_sign,
    input  logic            b_sign,
    input  logic [WEXP-1:0] a_exp,
    input  logic [WEXP-1:0] b_exp,
    input  logic [WSIG:0]   a_sig,
    input  logic [WSIG:0]   b_sig,
    input  logic            op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [WSIG+4:0] out_sum,
    output logic [WEXP-1:0] out_exp,
    output logic            out_sign,
    output logic            out_effop,
    output logic            out_zero
);

    localparam int unsigned M = WSIG + 1;
    localparam int unsigned W = M + GRS_W + 1;

    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Stage 1: compare/swap
    logic            b_eff_sign, eff, swap;
    logic [WEXP-1:0] x_exp, y_exp;
    logic [M-1:0]    x_sig, y_sig;
    logic            x_sign;

    always_comb begin
        b_eff_sign = b_sign ^ op;
        eff        = a_sign ^ b_eff_sign;
        swap       = {b_exp, b_sig} > {a_exp, a_sig};
        if (swap) begin
            x_exp  = b_exp;
            x_sig  = b_sig;
            y_exp  = a_exp;
            y_sig  = a_sig;
            x_sign = b_eff_sign;
        end else begin
            x_exp  = a_exp;
            x_sig  = a_sig;
            y_exp  = b_exp;
            y_sig  = b_sig;
            x_sign = a_sign;
        end
    end

    logic            s1_valid, s1_sign, s1_effop;
    logic [WEXP-1:0] s1_exp, s1_d;
    logic [M-1:0]    s1_xsig, s1_ysig;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_effop <= 1'b0;
            s1_exp   <= '0;
            s1_d     <= '0;
            s1_xsig  <= '0;
            s1_ysig  <= '0;
        end else if (en) begin
            s1_valid <= in_valid;
            s1_sign  <= x_sign;
            s1_effop <= eff;
            s1_exp   <= x_exp;
            s1_d     <= x_exp - y_exp;
            s1_xsig  <= x_sig;
            s1_ysig  <= y_sig;
        end
    end

    // Stage 2: align the smaller operand
    logic [W-1:0] s1_xw, s1_yw_raw, s1_yw;
    assign s1_xw     = {1'b0, s1_xsig, {GRS_W{1'b0}}};
    assign s1_yw_raw = {1'b0, s1_ysig, {GRS_W{1'b0}}};

    fpadd_align_shift #(
        .W    (W),
        .WAMT (WEXP)
    ) u_align (
        .din  (s1_yw_raw),
        .amt  (s1_d),
        .dout (s1_yw)
    );

    logic            s2_valid, s2_sign, s2_effop;
    logic [WEXP-1:0] s2_exp;
    logic [W-1:0]    s2_xw, s2_yw;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_sign  <= 1'b0;
            s2_effop <= 1'b0;
            s2_exp   <= '0;
            s2_xw    <= '0;
            s2_yw    <= '0;
        end else if (en) begin
            s2_valid <= s1_valid;
            s2_sign  <= s1_sign;
            s2_effop <= s1_effop;
            s2_exp   <= s1_exp;
            s2_xw    <= s1_xw;
            s2_yw    <= s1_yw;
        end
    end

    // Stage 3: effective add/subtract; x >= y so the difference never wraps
    logic [W-1:0] s2_sum;
    logic         s2_zero;

    always_comb begin
        s2_sum  = s2_effop ? (s2_xw - s2_yw) : (s2_xw + s2_yw);
        s2_zero = (s2_sum == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_exp   <= '0;
            out_sign  <= 1'b0;
            out_effop <= 1'b0;
            out_zero  <= 1'b0;
        end else if (en) begin
            out_valid <= s2_valid;
            out_sum   <= s2_sum;
            out_exp   <= s2_exp;
            out_sign  <= s2_zero ? 1'b0 : s2_sign;
            out_effop <= s2_effop;
            out_zero  <= s2_zero;
        end
    end

endmodule

// File: tb/tb_fpadd_mant_pipe.sv
// Bench for fpadd_mant_pipe: directed vector table, stall stream, reset flush
// and a randomized stream checked against an arithmetic reference model.
module tb_fpadd_mant_pipe;

    localparam int WEXP = 8;
    localparam int WSIG = 23;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic        a_sign, b_sign, op;
    logic [7:0]  a_exp, b_exp;
    logic [23:0] a_sig, b_sig;
    logic        out_valid, out_ready;
    logic [27:0] out_sum;
    logic [7:0]  out_exp;
    logic        out_sign, out_effop, out_zero;

    fpadd_mant_pipe #(
        .WEXP (WEXP),
        .WSIG (WSIG)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_sign    (a_sign),
        .b_sign    (b_sign),
        .a_exp     (a_exp),
        .b_exp     (b_exp),
        .a_sig     (a_sig),
        .b_sig     (b_sig),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_exp   (out_exp),
        .out_sign  (out_sign),
        .out_effop (out_effop),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        as;
        logic [7:0]  ae;
        logic [23:0] asg;
        logic        bs;
        logic [7:0]  be;
        logic [23:0] bsg;
        logic        opv;
        logic [27:0] esum;
        logic [7:0]  eexp;
        logic        esign;
        logic        eeff;
        logic        ezero;
    } vec_t;

    typedef struct {
        logic [27:0] sum;
        logic [7:0]  ex;
        logic        sign;
        logic        eff;
        logic        zero;
    } res_t;

    int checks = 0;
    int passed = 0;
    int npop   = 0;
    res_t q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, req);
    endtask

    // Reference: exact alignment by arithmetic shift, remainder gives sticky.
    function automatic res_t model(input logic sa, input logic [7:0] ea, input logic [23:0] ma,
                                   input logic sb, input logic [7:0] eb, input logic [23:0] mb,
                                   input logic opv);
        res_t r;
        logic sbp, eff, sg;
        longint unsigned va, vb, xs, ys, ext, kept, lost, yw, xw, sum;
        int d;
        sbp = sb ^ opv;
        eff = sa ^ sbp;
        va  = 64'({ea, ma});
        vb  = 64'({eb, mb});
        if (vb > va) begin
            xs = 64'(mb); ys = 64'(ma); d = int'(eb) - int'(ea); sg = sbp; r.ex = eb;
        end else begin
            xs = 64'(ma); ys = 64'(mb); d = int'(ea) - int'(eb); sg = sa; r.ex = ea;
        end
        ext = ys * 8;
        if (d >= 60) begin
            kept = 0;
            lost = ext;
        end else begin
            kept = ext >> d;
            lost = ext - (kept << d);
        end
        yw  = (kept & ~64'd1) | (((lost != 0) || kept[0]) ? 64'd1 : 64'd0);
        xw  = xs * 8;
        sum = (eff ? (xw - yw) : (xw + yw)) & 64'h0FFF_FFFF;
        r.sum  = sum[27:0];
        r.zero = (sum == 0);
        r.sign = r.zero ? 1'b0 : sg;
        r.eff  = eff;
        return r;
    endfunction

    // Monitor: samples mid-cycle, inputs change only just after posedge.
    res_t held;
    logic held_v = 1'b0;
    initial forever begin
        res_t e;
        @(negedge clk);
        if (reset) begin
            q.delete();
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_sum", 64'(out_sum), 64'(held.sum));
                chk("stall_exp", 64'(out_exp), 64'(held.ex));
                chk("stall_flags", 64'({out_sign, out_effop, out_zero}),
                    64'({held.sign, held.eff, held.zero}));
            end
            if (out_valid && !out_ready) begin
                chk("stall_in_ready", 64'(in_ready), 64'd0);
                held.sum = out_sum; held.ex = out_exp; held.sign = out_sign;
                held.eff = out_effop; held.zero = out_zero;
                held_v = 1'b1;
            end else begin
                held_v = 1'b0;
            end
            if (in_valid && in_ready)
                q.push_back(model(a_sign, a_exp, a_sig, b_sign, b_exp, b_sig, op));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_result", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("sb_sum", 64'(out_sum), 64'(e.sum));
                    chk("sb_exp", 64'(out_exp), 64'(e.ex));
                    chk("sb_sign", 64'(out_sign), 64'(e.sign));
                    chk("sb_effop", 64'(out_effop), 64'(e.eff));
                    chk("sb_zero", 64'(out_zero), 64'(e.zero));
                    npop++;
                end
            end
        end
    end

    task automatic drive(input vec_t v);
        a_sign = v.as; a_exp = v.ae; a_sig = v.asg;
        b_sign = v.bs; b_exp = v.be; b_sig = v.bsg; op = v.opv;
    endtask

    task automatic rand_op();
        int mode, off, e;
        mode   = int'($urandom_range(0, 9));
        a_sign = 1'($urandom_range(0, 1));
        b_sign = 1'($urandom_range(0, 1));
        op     = 1'($urandom_range(0, 1));
        e      = int'($urandom_range(20, 230));
        a_exp  = 8'(e);
        a_sig  = {1'b1, 23'($urandom)};
        off    = (mode == 2) ? int'($urandom_range(0, 20)) - 10 : int'($urandom_range(0, 64)) - 32;
        b_exp  = 8'(e + off);
        b_sig  = {1'b1, 23'($urandom)};
        if (mode == 0) begin
            a_exp = 8'd0;
            a_sig = 24'd0;
        end else if (mode == 1) begin
            b_exp = a_exp;
            b_sig = a_sig;
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        @(posedge clk); #1;
        drive(v);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk($sformatf("v%0d_in_ready", idx), 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk($sformatf("v%0d_latency", idx), 64'(lat), 64'd3);
        chk($sformatf("v%0d_sum", idx), 64'(out_sum), 64'(v.esum));
        chk($sformatf("v%0d_exp", idx), 64'(out_exp), 64'(v.eexp));
        chk($sformatf("v%0d_sign", idx), 64'(out_sign), 64'(v.esign));
        chk($sformatf("v%0d_effop", idx), 64'(out_effop), 64'(v.eeff));
        chk($sformatf("v%0d_zero", idx), 64'(out_zero), 64'(v.ezero));
    endtask

    vec_t vecs[7];

    initial begin
        int idx, cyc, npop0;
        logic acc;
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int idx, cyc, npop0;
        logic acc;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a_sign = 0; b_sign = 0; op = 0; a_exp = 0; b_exp = 0; a_sig = 0; b_sig = 0;

        repeat (2) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_sum", 64'(out_sum), 64'd0);
        chk("rst_out_exp", 64'(out_exp), 64'd0);
        chk("rst_out_flags", 64'({out_sign, out_effop, out_zero}), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        reset = 1'b0;

        //            as ae     asg         bs be     bsg         op esum          eexp   sg ef z
        vecs[0] = '{0, 8'd127, 24'h800000, 0, 8'd127, 24'h800000, 0, 28'h8000000, 8'd127, 0, 0, 0};
        vecs[1] = '{0, 8'd127, 24'h800000, 0, 8'd127, 24'h800000, 1, 28'h0000000, 8'd127, 0, 1, 1};
        vecs[2] = '{0, 8'd126, 24'hC00000, 0, 8'd127, 24'h800000, 1, 28'h1000000, 8'd127, 1, 1, 0};
        vecs[3] = '{0, 8'd127, 24'h800000, 0, 8'd97,  24'h800000, 0, 28'h4000001, 8'd127, 0, 0, 0};
        vecs[4] = '{0, 8'd127, 24'hC00000, 1, 8'd127, 24'h800000, 0, 28'h2000000, 8'd127, 0, 1, 0};
        vecs[5] = '{0, 8'd127, 24'h800000, 0, 8'd123, 24'h800001, 0, 28'h4400001, 8'd127, 0, 0, 0};
        vecs[6] = '{0, 8'd0,   24'h000000, 0, 8'd127, 24'h800000, 1, 28'h4000000, 8'd127, 1, 1, 0};
        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Back-to-back stream with the consumer stalled in cycles 4-8
        npop0 = npop; idx = 0; cyc = 0;
        @(posedge clk); #1;
        while ((idx < 8 || q.size() != 0) && cyc < 60) begin
            if (idx < 8) begin
                a_sign = 0; b_sign = 0; op = 1'(idx % 2);
                a_exp = 8'(100 + idx); a_sig = 24'h800000 | 24'(idx * 24'h01234);
                b_exp = 8'(98 + 2 * idx); b_sig = 24'hA00000 + 24'(idx);
            end
            in_valid  = (idx < 8);
            out_ready = !(cyc >= 4 && cyc <= 8);
            @(negedge clk);
            acc = in_valid && in_ready;
            if (cyc == 6) chk("stream_in_ready_low", 64'(in_ready), 64'd0);
            @(posedge clk); #1;
            if (acc) idx++;
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("stream_count", 64'(npop - npop0), 64'd8);
        chk("stream_drained", 64'(q.size()), 64'd0);

        // Randomized stream with random backpressure
        for (int c = 0; c < 400; c++) begin
            rand_op();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        cyc = 0;
        while (q.size() != 0 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("random_drained", 64'(q.size()), 64'd0);

        // Reset with two operations in flight
        rand_op(); in_valid = 1'b1;
        @(posedge clk); #1;
        rand_op();
        @(posedge clk); #1;
        in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_reset_valid", 64'(out_valid), 64'd0);
        end
        run_vec(vecs[2], 7);
        @(posedge clk); #1;
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
